// File: rtl/jedro_1_defines.sv
// rtl/jedro_1_defines.sv - shared jedro_1 type and constant definitions
package jedro_1_defines;

  typedef enum logic [2:0] {
    BR_EQ  = 3'b000,
    BR_NE  = 3'b001,
    BR_LT  = 3'b100,
    BR_GE  = 3'b101,
    BR_LTU = 3'b110,
    BR_GEU = 3'b111
  } branch_op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } branch_state_e;

  localparam logic COND_TRUE  = 1'b1;
  localparam logic COND_FALSE = 1'b0;

endpackage

// File: rtl/jedro_1_branch_cmp.sv
// rtl/jedro_1_branch_cmp.sv - combinational branch condition evaluator
module jedro_1_branch_cmp
  import jedro_1_defines::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] rs1,
  input  logic [DATA_WIDTH-1:0] rs2,
  output logic                  cond,
  output logic                  illegal
);

  always_comb begin
    cond    = COND_FALSE;
    illegal = 1'b0;
    case (branch_op_e'(op))
      BR_EQ:   cond = (rs1 == rs2);
      BR_NE:   cond = (rs1 != rs2);
      BR_LT:   cond = ($signed(rs1) < $signed(rs2));
      BR_GE:   cond = ($signed(rs1) >= $signed(rs2));
      BR_LTU:  cond = (rs1 < rs2);
      BR_GEU:  cond = (rs1 >= rs2);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/jedro_1_branch_unit.sv
// rtl/jedro_1_branch_unit.sv - registered branch resolution with fetch flush
module jedro_1_branch_unit
  import jedro_1_defines::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int ALIGN_BITS   = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [2:0]            op_i,
  input  logic [DATA_WIDTH-1:0] rs1_i,
  input  logic [DATA_WIDTH-1:0] rs2_i,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic [ADDR_WIDTH-1:0] imm_i,
  output logic                  valid_o,
  output logic                  taken_o,
  output logic [ADDR_WIDTH-1:0] target_o,
  output logic                  flush_o,
  output logic                  misaligned_o,
  output logic                  illegal_o,
  output logic [CNT_WIDTH-1:0]  resolved_cnt_o,
  output logic [CNT_WIDTH-1:0]  taken_cnt_o
);

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = (ADDR_WIDTH'(1) << ALIGN_BITS) - ADDR_WIDTH'(1);
  localparam logic [3:0]            FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  branch_state_e         state, state_next;
  logic [3:0]            flush_cnt, flush_cnt_next;
  logic                  cond, illegal;
  logic [ADDR_WIDTH-1:0] target;
  logic                  accept, misaligned, take, trap_mis, resolve;

  jedro_1_branch_cmp #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_cmp (
    .op      (op_i),
    .rs1     (rs1_i),
    .rs2     (rs2_i),
    .cond    (cond),
    .illegal (illegal)
  );

  assign ready_o    = (state == IDLE);
  assign flush_o    = (state == FLUSH);
  assign accept     = valid_i && ready_o;
  assign target     = pc_i + imm_i;
  assign misaligned = |(target & ALIGN_MASK);
  // Misaligned taken branches trap instead of redirecting fetch.
  assign take       = accept && !illegal && cond && !misaligned;
  assign trap_mis   = accept && !illegal && cond && misaligned;
  assign resolve    = accept && !illegal;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      flush_cnt <= '0;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
    end
  end

  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    case (state)
      IDLE: begin
        if (take) begin
          state_next     = FLUSH;
          flush_cnt_next = FLUSH_LOAD;
        end
      end
      FLUSH: begin
        if (flush_cnt == 4'd0) state_next = IDLE;
        else flush_cnt_next = flush_cnt - 4'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o        <= 1'b0;
      taken_o        <= 1'b0;
      misaligned_o   <= 1'b0;
      illegal_o      <= 1'b0;
      target_o       <= '0;
      resolved_cnt_o <= '0;
      taken_cnt_o    <= '0;
    end else begin
      valid_o      <= accept;
      taken_o      <= take;
      misaligned_o <= trap_mis;
      illegal_o    <= accept && illegal;
      if (accept) target_o <= target;
      if (resolve) resolved_cnt_o <= resolved_cnt_o + CNT_WIDTH'(1);
      if (take) taken_cnt_o <= taken_cnt_o + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_jedro_1_branch_unit.sv
// tb/tb_jedro_1_branch_unit.sv - directed self-checking bench for jedro_1_branch_unit
module tb_jedro_1_branch_unit;

  logic        clk, rst;
  logic        valid, ready, valid_out, taken, flush, misaligned, illegal;
  logic [2:0]  op;
  logic [31:0] rs1, rs2, pc, imm, target, resolved_cnt, taken_cnt;

  logic        valid2, ready2, valid_out2, taken2, flush2, misaligned2, illegal2;
  logic [2:0]  op2;
  logic [31:0] rs1_2, rs2_2, pc2, imm2, target2;
  logic [3:0]  resolved_cnt2, taken_cnt2;

  int checks = 0;
  int errors = 0;

  jedro_1_branch_unit dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(ready), .op_i(op),
    .rs1_i(rs1), .rs2_i(rs2), .pc_i(pc), .imm_i(imm), .valid_o(valid_out),
    .taken_o(taken), .target_o(target), .flush_o(flush), .misaligned_o(misaligned),
    .illegal_o(illegal), .resolved_cnt_o(resolved_cnt), .taken_cnt_o(taken_cnt)
  );

  jedro_1_branch_unit #(.FLUSH_CYCLES(1), .CNT_WIDTH(4)) dut_small (
    .clk_i(clk), .rst_i(rst), .valid_i(valid2), .ready_o(ready2), .op_i(op2),
    .rs1_i(rs1_2), .rs2_i(rs2_2), .pc_i(pc2), .imm_i(imm2), .valid_o(valid_out2),
    .taken_o(taken2), .target_o(target2), .flush_o(flush2), .misaligned_o(misaligned2),
    .illegal_o(illegal2), .resolved_cnt_o(resolved_cnt2), .taken_cnt_o(taken_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic [31:0] i);
    @(negedge clk);
    valid = 1'b1; op = o; rs1 = a; rs2 = b; pc = p; imm = i;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] p, input logic [31:0] i);
    drive(o, a, b, p, i);
    step();
    valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; op = 3'b000; rs1 = '0; rs2 = '0; pc = '0; imm = '0;
    valid2 = 1'b0; op2 = 3'b000; rs1_2 = '0; rs2_2 = '0; pc2 = '0; imm2 = '0;
    step();
    step();
    chk("rst_valid", valid_out, 0);
    chk("rst_ready", ready, 1);
    chk("rst_flush", flush, 0);
    chk("rst_target", target, 0);
    chk("rst_resolved", resolved_cnt, 0);
    chk("rst_taken_cnt", taken_cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    // bne equal operands: not taken
    req(3'b001, 32'd5, 32'd5, 32'h100, 32'd8);
    chk("bne_nt_valid", valid_out, 1);
    chk("bne_nt_taken", taken, 0);
    chk("bne_nt_flush", flush, 0);
    chk("bne_nt_target", target, 32'h108);
    chk("bne_nt_resolved", resolved_cnt, 1);
    step();
    chk("bne_nt_pulse", valid_out, 0);
    chk("bne_nt_flush2", flush, 0);

    // bne taken, negative immediate
    req(3'b001, 32'd3, 32'd0, 32'h100, 32'hFFFF_FFF0);
    chk("bne_t_valid", valid_out, 1);
    chk("bne_t_taken", taken, 1);
    chk("bne_t_target", target, 32'hF0);
    chk("bne_t_flush1", flush, 1);
    chk("bne_t_ready1", ready, 0);
    chk("bne_t_taken_cnt", taken_cnt, 1);
    chk("bne_t_resolved", resolved_cnt, 2);
    step();
    chk("bne_t_flush2", flush, 1);
    chk("bne_t_ready2", ready, 0);
    chk("bne_t_valid2", valid_out, 0);
    chk("bne_t_target_hold", target, 32'hF0);
    step();
    chk("bne_t_flush3", flush, 0);
    chk("bne_t_ready3", ready, 1);

    // signed vs unsigned compares
    req(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h20);
    chk("blt_taken", taken, 1);
    chk("blt_target", target, 32'h220);
    step(); step();
    req(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h20);
    chk("bltu_valid", valid_out, 1);
    chk("bltu_taken", taken, 0);
    chk("bltu_flush", flush, 0);
    req(3'b101, 32'd7, 32'd7, 32'h0, 32'h4);
    chk("bge_taken", taken, 1);
    step(); step();
    req(3'b111, 32'd0, 32'd0, 32'h0, 32'h8);
    chk("bgeu_taken", taken, 1);
    chk("bgeu_resolved", resolved_cnt, 6);
    chk("bgeu_taken_cnt", taken_cnt, 4);
    step(); step();

    // misaligned taken target, then illegal op back-to-back
    drive(3'b000, 32'd1, 32'd1, 32'h100, 32'd6);
    step();
    op = 3'b010;
    chk("mis_flag", misaligned, 1);
    chk("mis_taken", taken, 0);
    chk("mis_valid", valid_out, 1);
    chk("mis_flush", flush, 0);
    chk("mis_ready", ready, 1);
    chk("mis_target", target, 32'h106);
    chk("mis_resolved", resolved_cnt, 7);
    chk("mis_taken_cnt", taken_cnt, 4);
    step();
    valid = 1'b0;
    chk("ill_flag", illegal, 1);
    chk("ill_valid", valid_out, 1);
    chk("ill_taken", taken, 0);
    chk("ill_mis", misaligned, 0);
    chk("ill_flush", flush, 0);
    chk("ill_resolved", resolved_cnt, 7);
    chk("ill_taken_cnt", taken_cnt, 4);
    step();
    chk("ill_pulse", illegal, 0);

    // valid_i held through a flush
    drive(3'b000, 32'd1, 32'd1, 32'h0, 32'h40);
    step();
    op = 3'b001; rs1 = 32'd2; rs2 = 32'd2; pc = 32'h300; imm = 32'h4;
    chk("hold_first_taken", taken, 1);
    chk("hold_first_target", target, 32'h40);
    step();
    chk("hold_blocked_valid", valid_out, 0);
    chk("hold_flush", flush, 1);
    step();
    chk("hold_blocked_valid2", valid_out, 0);
    chk("hold_ready_back", ready, 1);
    step();
    valid = 1'b0;
    chk("hold_second_valid", valid_out, 1);
    chk("hold_second_taken", taken, 0);
    chk("hold_second_target", target, 32'h304);
    chk("hold_resolved", resolved_cnt, 9);
    chk("hold_taken_cnt", taken_cnt, 5);

    // reset pulsed in the first flush cycle
    req(3'b001, 32'd1, 32'd0, 32'h0, 32'h10);
    chk("rstf_flush_before", flush, 1);
    rst = 1'b1;
    #1;
    chk("rstf_flush", flush, 0);
    chk("rstf_ready", ready, 1);
    chk("rstf_valid", valid_out, 0);
    chk("rstf_taken_cnt", taken_cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    // 4-bit counters wrap; single-cycle flush
    @(negedge clk);
    valid2 = 1'b1; op2 = 3'b000; rs1_2 = 32'd1; rs2_2 = 32'd2; pc2 = 32'h0; imm2 = 32'h4;
    repeat (17) step();
    chk("wrap_resolved", 32'(resolved_cnt2), 1);
    chk("wrap_valid", valid_out2, 1);
    chk("wrap_ready", ready2, 1);
    op2 = 3'b001; rs1_2 = 32'd1; rs2_2 = 32'd0; imm2 = 32'h8;
    step();
    valid2 = 1'b0;
    chk("f1_taken", taken2, 1);
    chk("f1_flush", flush2, 1);
    chk("f1_ready", ready2, 0);
    chk("f1_target", target2, 32'h8);
    chk("f1_taken_cnt", 32'(taken_cnt2), 1);
    step();
    chk("f1_flush_end", flush2, 0);
    chk("f1_ready_back", ready2, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jedro_1_branch_unit.md
# jedro_1_branch_unit

Registered branch-resolution unit for the jedro_1 core. It takes a decoded conditional branch (RV32I funct3 encodings), evaluates the condition, computes the target, and emits a one-cycle result. It also drives a parametrised pipeline flush and keeps taken/resolved performance counters. It sits between the decoder/regfile read stage and the fetch unit, and generalises the core's single-condition bne path to all six compare modes.

## Interface
- DATA_WIDTH, 32, operand width
- ADDR_WIDTH, 32, PC/target width
- FLUSH_CYCLES, 2, cycles flush_o stays high after a taken branch; legal range 1..15
- ALIGN_BITS, 2, low target bits that must be zero (1 when compressed support is added)
- CNT_WIDTH, 32, performance counter width

- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- valid_i  in  1  branch request valid
- ready_o  out  1  unit can accept a request
- op_i  in  3  funct3: 000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu
- rs1_i, rs2_i  in  DATA_WIDTH  operands
- pc_i  in  ADDR_WIDTH  PC of the branch
- imm_i  in  ADDR_WIDTH  sign-extended B-immediate
- valid_o  out  1  result pulse
- taken_o  out  1  branch taken (qualified by valid_o)
- target_o  out  ADDR_WIDTH  pc_i+imm_i, registered
- flush_o  out  1  kill younger instructions and redirect fetch to target_o
- misaligned_o  out  1  taken target violates ALIGN_BITS
- illegal_o  out  1  op_i is 010 or 011
- resolved_cnt_o, taken_cnt_o  out  CNT_WIDTH  performance counters

## Operation
- Accept on valid_i && ready_o. In IDLE, ready_o = 1.
- Compare:
  - beq/bne use equality.
  - blt/bge use signed DATA_WIDTH compare.
  - bltu/bgeu use unsigned compare.
- Target is pc_i+imm_i, modulo 2^ADDR_WIDTH; wrap-around is silent.
- Illegal op: valid_o=1, illegal_o=1, taken_o=0. No flush. Counters unchanged.
- Taken with target[ALIGN_BITS-1:0] != 0:
  - valid_o=1, misaligned_o=1, taken_o=0.
  - No flush. resolved_cnt increments; taken_cnt does not.
- Taken and aligned:
  - valid_o=1, taken_o=1. Both counters increment.
  - FSM goes to FLUSH.
- Not taken: valid_o=1, taken_o=0, resolved_cnt increments.
- FSM states:
  - IDLE: on an accepted taken+aligned request, go to FLUSH and load the flush counter with FLUSH_CYCLES-1.
  - FLUSH: flush_o=1, ready_o=0, count down; on 0, go to IDLE.
- valid_i during FLUSH is not accepted. The requester holds it; it is not dropped by the unit.
- Counters wrap to 0 on overflow.
- target_o holds its last value between pulses. misaligned_o, illegal_o, valid_o and taken_o are single-cycle pulses.

## Timing
- Reset values: valid_o, taken_o, flush_o, misaligned_o, illegal_o, target_o, both counters = 0. ready_o = 1. State = IDLE.
- Latency is 1 cycle: request accepted at edge N gives valid_o/taken_o/target_o in cycle N+1.
- flush_o is high in cycles N+1 .. N+FLUSH_CYCLES, coincident with valid_o in cycle N+1.
- ready_o is low in the same cycles N+1 .. N+FLUSH_CYCLES. The next request can be accepted at edge N+FLUSH_CYCLES+1.
- Not-taken or trapped branches allow back-to-back acceptance every cycle.
- Counters update at the edge after acceptance and are visible in the same cycle as valid_o.
- rst_i asserted mid-FLUSH immediately drops flush_o and returns to IDLE. The in-flight result is discarded.

## Structure
- Shared package jedro_1_defines gains:
  - branch_op_e enum (funct3 values)
  - branch_state_e {IDLE, FLUSH}
  - compare-result localparams
- One combinational sub-module, jedro_1_branch_cmp (op, rs1, rs2 -> cond, illegal), instantiated once and reused by future jal/jalr work.
- The FSM, flush counter, output registers and perf counters live in the top module.

## Test plan
- bne rs1=5, rs2=5, pc=0x100, imm=8 -> valid_o pulse, taken_o=0, flush_o never high, resolved_cnt=1.
- bne rs1=3, rs2=0, pc=0x100, imm=-16 -> taken_o=1, target_o=0xF0, flush_o high 2 cycles, ready_o low 2 cycles, taken_cnt=1.
- blt rs1=0xFFFFFFFF, rs2=1 -> taken; same operands with bltu -> not taken; bge 7,7 and bgeu 0,0 -> taken.
- beq taken with imm=6, ALIGN_BITS=2 -> misaligned_o=1, taken_o=0, no flush. op_i=010 -> illegal_o=1, counters unchanged.
- valid_i held high through a flush -> second request accepted exactly at edge N+FLUSH_CYCLES+1. rst_i pulsed in the first flush cycle -> flush_o=0 and ready_o=1 at once.
- CNT_WIDTH=4, 17 not-taken branches back-to-back -> resolved_cnt_o=1 (wrap). FLUSH_CYCLES=1 -> single-cycle flush.
